sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO with width/depth generics, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags. It is the same-clock successor to the 2-entry CDC FIFOs. It buffers AXI channel payloads (e.g. {WDATA,WSTRB,WLAST}) inside one clock domain, in the master/slave wrappers and the DMA. Read side is show-ahead: the head entry is visible on rdata whenever rempty=0.

Parameters:
DATA_W, 37, payload width in bits.
DEPTH, 4, number of entries; must be a power of 2 and >=2.
AF_LVL, DEPTH-1, almost_full asserts when count >= AF_LVL.
AE_LVL, 1, almost_empty asserts when count <= AE_LVL.
PTR_W (localparam), $clog2(DEPTH)+1, pointer width including the wrap bit.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of the FIFO contents.
wpush  in  1  write request.
wdata  in  DATA_W  write payload.
wfull  out  1  FIFO full.
walmost_full  out  1  count >= AF_LVL.
rpop  in  1  read request; consumes the head entry.
rdata  out  DATA_W  head entry; 0 when empty.
rempty  out  1  FIFO empty.
ralmost_empty  out  1  count <= AE_LVL.
count  out  PTR_W  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a push was attempted while full.
underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (async assert, release on clock edge):
  - wptr=rptr=0; mem all 0; overflow=underflow=0.
  - Outputs: rempty=1, wfull=0, count=0, rdata=0, walmost_full=(0>=AF_LVL), ralmost_empty=1.
- Pointers: PTR_W bits; index = ptr[PTR_W-2:0]; increments wrap naturally modulo 2^PTR_W.
- Flags, all combinational from the registered pointers:
  - rempty = (wptr==rptr).
  - wfull = MSBs differ and lower bits equal.
  - count = wptr-rptr (PTR_W-bit modular subtraction).
- Write: wen = wpush & ~wfull. On wen, mem[widx]<=wdata and wptr+1.
- Read: ren = rpop & ~rempty. On ren, rptr+1.
- rdata = rempty ? 0 : mem[ridx], combinational (show-ahead).
- Latency: a push in cycle N makes the data visible on rdata, with rempty=0, from cycle N+1. A pop in cycle N exposes the next entry in N+1.
- Simultaneous push and pop:
  - Not full and not empty: both occur; count unchanged.
  - Full: pop occurs, push is rejected (wfull is sampled before the pop); count becomes DEPTH-1; overflow sets.
  - Empty: push occurs, pop is ignored; underflow sets.
- overflow sets on wpush & wfull; underflow sets on rpop & rempty. Both hold until rst or flush.
- flush has priority over push and pop in the same cycle:
  - wptr=rptr=0, overflow=underflow=0; mem is not cleared.
  - Next cycle: rempty=1, count=0. Any push in the flush cycle is dropped.
- Reset mid-operation: immediate return to the reset state; in-flight data is lost.
- Parameter checks: elaboration-time assertion for DEPTH a power of 2, AF_LVL in 1..DEPTH, AE_LVL in 0..DEPTH-1.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1;
  - a status struct typedef {full, almost_full, empty, almost_empty, overflow, underflow} for status buses;
  - the AXI W payload field offsets (WLAST bit 0, WSTRB bits 4:1, WDATA bits 36:5) and W_PAYLOAD_W=37.
- One sub-module, fifo_ram_2p: parametrised DEPTH x DATA_W storage with a synchronous write port and an asynchronous read port. Pointer/flag logic stays in the top.

Test Plan:
- DEPTH=4: reset, then push A,B,C,D -> rdata=A one cycle after the first push; count 1,2,3,4; walmost_full at count 3; wfull at 4; ralmost_empty deasserts at count 2.
- Full FIFO, push E without pop -> E dropped, overflow=1 (sticky), count=4. Then 4 pops -> rdata A,B,C,D in order; rempty=1; rdata=0.
- Full FIFO, push and pop together -> A popped, push rejected, count=3. Then at count=2, push and pop together -> count stays 2, order preserved.
- Empty FIFO, push X and pop together -> X stored, count=1, underflow=1.
- Continuous push/pop at count=2 for 20 cycles -> pointers wrap past 2^PTR_W; data ordering intact; wfull and rempty never assert.
- Count=3 with overflow=1, assert flush together with a push -> next cycle count=0, rempty=1, overflow=0, pushed word dropped. Assert rst asynchronously mid-burst -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the same-clock FIFO family.
// Holds pointer sizing, the status bundle and the AXI W payload layout.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // AXI W channel payload packed as {WDATA, WSTRB, WLAST}
  localparam int W_PAYLOAD_W = 37;
  localparam int WLAST_BIT   = 0;
  localparam int WSTRB_LSB   = 1;
  localparam int WSTRB_MSB   = 4;
  localparam int WDATA_LSB   = 5;
  localparam int WDATA_MSB   = 36;

endpackage

// File: rtl/fifo_ram_2p.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
// Contents clear on reset so an unwritten slot always reads as zero.
module fifo_ram_2p #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock show-ahead FIFO with occupancy, programmable almost flags,
// synchronous flush and sticky overflow/underflow errors.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = W_PAYLOAD_W,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wpush,
  input  logic [DATA_W-1:0] wdata,
  output logic              wfull,
  output logic              walmost_full,
  input  logic              rpop,
  output logic [DATA_W-1:0] rdata,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [PTR_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = PTR_W - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LVL must be in 1..DEPTH");
  end
  if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LVL must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]  wptr, rptr, occ;
  logic              full, empty, wen, ren, ovf_q, unf_q;
  logic [DATA_W-1:0] ram_rdata;
  fifo_status_t      st;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign occ   = wptr - rptr;

  // Full/empty are sampled before this cycle's pop/push, so a push into a
  // full FIFO is rejected even when a pop happens alongside it.
  assign wen = wpush & ~full;
  assign ren = rpop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wen)           wptr  <= wptr + 1'b1;
      if (ren)           rptr  <= rptr + 1'b1;
      if (wpush && full) ovf_q <= 1'b1;
      if (rpop && empty) unf_q <= 1'b1;
    end
  end

  fifo_ram_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wen & ~flush),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign st.full         = full;
  assign st.almost_full  = (occ >= PTR_W'(AF_LVL));
  assign st.empty        = empty;
  assign st.almost_empty = (occ <= PTR_W'(AE_LVL));
  assign st.overflow     = ovf_q;
  assign st.underflow    = unf_q;

  assign wfull         = st.full;
  assign walmost_full  = st.almost_full;
  assign rempty        = st.empty;
  assign ralmost_empty = st.almost_empty;
  assign overflow      = st.overflow;
  assign underflow     = st.underflow;
  assign count         = occ;
  assign rdata         = empty ? '0 : ram_rdata;

endmodule
